// File: rtl/sgmii_rx_word_sync.sv
// Receive word-alignment and sync qualification for an SGMII lane: slips the
// deserialiser until K28.5 commas land on the word boundary, then tracks sync.
module sgmii_rx_word_sync #(
    parameter int P_HUNT_WINDOW = 32,
    parameter int P_SLIP_WAIT   = 8,
    parameter int P_COMMA_CNT   = 3,
    parameter int P_ERR_MAX     = 4,
    parameter int P_GOOD_RUN    = 4
) (
    input  logic       i_Clk,
    input  logic       i_ARst,
    input  logic       i_PllLocked,
    input  logic [7:0] i8_RxCodeGroup,
    input  logic       i_RxCodeCtrl,
    input  logic       i_RxCodeInvalid,
    output logic       o_RxBitSlip,
    output logic       o_SyncStatus,
    output logic [7:0] o8_RxCodeGroup,
    output logic       o_RxCodeCtrl,
    output logic       o_RxDataValid,
    output logic [3:0] o4_SlipCnt,
    output logic [1:0] o2_State
);

    localparam int WIN_W  = $clog2(P_HUNT_WINDOW + 1);
    localparam int WAIT_W = $clog2(P_SLIP_WAIT + 1);
    localparam int CMA_W  = $clog2(P_COMMA_CNT + 1);
    localparam int ERR_W  = $clog2(P_ERR_MAX + 1);
    localparam int GOOD_W = $clog2(P_GOOD_RUN + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(P_HUNT_WINDOW - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(P_SLIP_WAIT - 1);
    localparam logic [CMA_W-1:0]  CMA_LAST  = CMA_W'(P_COMMA_CNT - 1);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(P_ERR_MAX - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(P_GOOD_RUN - 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_VERIFY    = 2'd2,
        ST_SYNC      = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WIN_W-1:0]    win_cnt, win_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [CMA_W-1:0]    comma_cnt, comma_nxt;
    logic [ERR_W-1:0]    err_cnt, err_nxt;
    logic [GOOD_W-1:0]   good_cnt, good_nxt;
    logic                slip, slip_nxt;
    logic [3:0]          slip_cnt, slip_cnt_nxt;
    logic                comma;
    logic                win_last;

    assign comma    = i_RxCodeCtrl & (i8_RxCodeGroup == 8'hBC) & ~i_RxCodeInvalid;
    assign win_last = (win_cnt == WIN_LAST);

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            state     <= ST_HUNT;
            win_cnt   <= '0;
            wait_cnt  <= '0;
            comma_cnt <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
            slip      <= 1'b0;
            slip_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            win_cnt   <= win_nxt;
            wait_cnt  <= wait_nxt;
            comma_cnt <= comma_nxt;
            err_cnt   <= err_nxt;
            good_cnt  <= good_nxt;
            slip      <= slip_nxt;
            slip_cnt  <= slip_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        win_nxt      = win_cnt;
        wait_nxt     = wait_cnt;
        comma_nxt    = comma_cnt;
        err_nxt      = err_cnt;
        good_nxt     = good_cnt;
        slip_nxt     = 1'b0;
        slip_cnt_nxt = slip_cnt;

        // Loss of PLL lock overrides everything; the slip count is history and survives.
        if (!i_PllLocked) begin
            state_nxt = ST_HUNT;
            win_nxt   = '0;
            wait_nxt  = '0;
            comma_nxt = '0;
            err_nxt   = '0;
            good_nxt  = '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (comma) begin
                        state_nxt = ST_VERIFY;
                        comma_nxt = CMA_W'(1);
                        win_nxt   = '0;
                    end else if (win_last) begin
                        state_nxt    = ST_SLIP_WAIT;
                        slip_nxt     = 1'b1;
                        slip_cnt_nxt = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                        win_nxt      = '0;
                        wait_nxt     = '0;
                    end else begin
                        win_nxt = win_cnt + WIN_W'(1);
                    end
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_HUNT;
                        wait_nxt  = '0;
                        win_nxt   = '0;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (i_RxCodeInvalid) begin
                        state_nxt = ST_HUNT;
                        win_nxt   = '0;
                        comma_nxt = '0;
                    end else if (comma) begin
                        win_nxt = '0;
                        if (comma_cnt == CMA_LAST) begin
                            state_nxt = ST_SYNC;
                            comma_nxt = '0;
                            err_nxt   = '0;
                            good_nxt  = '0;
                        end else begin
                            comma_nxt = comma_cnt + CMA_W'(1);
                        end
                    end else if (win_last) begin
                        state_nxt = ST_HUNT;
                        win_nxt   = '0;
                        comma_nxt = '0;
                    end else begin
                        win_nxt = win_cnt + WIN_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (i_RxCodeInvalid) begin
                        good_nxt = '0;
                        if (err_cnt == ERR_LAST) begin
                            state_nxt = ST_HUNT;
                            err_nxt   = '0;
                            win_nxt   = '0;
                        end else begin
                            err_nxt = err_cnt + ERR_W'(1);
                        end
                    end else if (err_cnt != '0) begin
                        if (good_cnt == GOOD_LAST) begin
                            err_nxt  = err_cnt - ERR_W'(1);
                            good_nxt = '0;
                        end else begin
                            good_nxt = good_cnt + GOOD_W'(1);
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // Datapath: fixed one-cycle latency, valid qualified by the sync state seen with the input.
    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            o8_RxCodeGroup <= '0;
            o_RxCodeCtrl   <= 1'b0;
            o_RxDataValid  <= 1'b0;
        end else begin
            o8_RxCodeGroup <= i8_RxCodeGroup;
            o_RxCodeCtrl   <= i_RxCodeCtrl;
            o_RxDataValid  <= (state == ST_SYNC) & ~i_RxCodeInvalid;
        end
    end

    assign o_RxBitSlip  = slip;
    assign o_SyncStatus = (state == ST_SYNC);
    assign o4_SlipCnt   = slip_cnt;
    assign o2_State     = state;

endmodule

// File: tb/tb_sgmii_rx_word_sync.sv
// Directed and randomized bench for sgmii_rx_word_sync, checked every cycle
// against a rule-level reference model and a one-deep expected-data queue.
module tb_sgmii_rx_word_sync;

    localparam int HW = 32;
    localparam int SW = 8;
    localparam int CC = 3;
    localparam int EM = 4;
    localparam int GR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll = 1'b0;
    logic [7:0] grp = 8'h00;
    logic       ctrl = 1'b0;
    logic       inv = 1'b0;

    logic       o_RxBitSlip;
    logic       o_SyncStatus;
    logic [7:0] o8_RxCodeGroup;
    logic       o_RxCodeCtrl;
    logic       o_RxDataValid;
    logic [3:0] o4_SlipCnt;
    logic [1:0] o2_State;

    sgmii_rx_word_sync dut (
        .i_Clk           (clk),
        .i_ARst          (rst),
        .i_PllLocked     (pll),
        .i8_RxCodeGroup  (grp),
        .i_RxCodeCtrl    (ctrl),
        .i_RxCodeInvalid (inv),
        .o_RxBitSlip     (o_RxBitSlip),
        .o_SyncStatus    (o_SyncStatus),
        .o8_RxCodeGroup  (o8_RxCodeGroup),
        .o_RxCodeCtrl    (o_RxCodeCtrl),
        .o_RxDataValid   (o_RxDataValid),
        .o4_SlipCnt      (o4_SlipCnt),
        .o2_State        (o2_State)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    // reference model: phase 0 hunt, 1 settling after slip, 2 verifying, 3 in sync
    int m_phase, m_since_comma, m_settle_left, m_commas, m_errs, m_run, m_slip, m_slips;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_since_comma = 0; m_settle_left = 0; m_commas = 0;
        m_errs = 0; m_run = 0; m_slip = 0; m_slips = 0;
        exp_q.delete();
    endtask

    task automatic model_update(input logic p, input logic [7:0] g, input logic c, input logic v);
        bit is_comma;
        is_comma = c && (g == 8'hBC) && !v;
        m_slip = 0;
        if (!p) begin
            m_phase = 0; m_since_comma = 0; m_settle_left = 0;
            m_commas = 0; m_errs = 0; m_run = 0;
        end else if (m_phase == 0) begin
            if (is_comma) begin
                m_phase = 2; m_commas = 1; m_since_comma = 0;
            end else if (m_since_comma == HW - 1) begin
                m_phase = 1; m_slip = 1; m_slips = (m_slips + 1) % 10;
                m_settle_left = SW; m_since_comma = 0;
            end else begin
                m_since_comma++;
            end
        end else if (m_phase == 1) begin
            m_settle_left--;
            if (m_settle_left == 0) begin
                m_phase = 0; m_since_comma = 0;
            end
        end else if (m_phase == 2) begin
            if (v) begin
                m_phase = 0; m_since_comma = 0; m_commas = 0;
            end else if (is_comma) begin
                m_commas++; m_since_comma = 0;
                if (m_commas == CC) begin
                    m_phase = 3; m_commas = 0; m_errs = 0; m_run = 0;
                end
            end else if (m_since_comma == HW - 1) begin
                m_phase = 0; m_since_comma = 0; m_commas = 0;
            end else begin
                m_since_comma++;
            end
        end else begin
            if (v) begin
                m_errs++; m_run = 0;
                if (m_errs == EM) begin
                    m_phase = 0; m_errs = 0; m_since_comma = 0;
                end
            end else if (m_errs > 0) begin
                m_run++;
                if (m_run == GR) begin
                    m_errs--; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // compare outputs to the model, then drive the next input and advance the model
    task automatic cycle_io(input logic p, input logic [7:0] g, input logic c, input logic v);
        logic [9:0] e;
        chk("state", o2_State, m_phase);
        chk("sync", o_SyncStatus, (m_phase == 3));
        chk("bitslip", o_RxBitSlip, m_slip);
        chk("slipcnt", o4_SlipCnt, m_slips);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'd0;
        chk("rx_data", {o_RxDataValid, o_RxCodeCtrl, o8_RxCodeGroup}, e);
        pll = p; grp = g; ctrl = c; inv = v;
        exp_q.push_back({(m_phase == 3) && !v, c, g});
        model_update(p, g, c, v);
    endtask

    task automatic step(input logic p, input logic [7:0] g, input logic c, input logic v);
        @(negedge clk);
        cycle_io(p, g, c, v);
    endtask

    task automatic send_comma();
        step(1'b1, 8'hBC, 1'b1, 1'b0);
    endtask

    task automatic send_d();
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    task automatic send_inv();
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, o2_State, 0);
        chk({tag, "_sync"}, o_SyncStatus, 0);
        chk({tag, "_slip"}, o_RxBitSlip, 0);
        chk({tag, "_slipcnt"}, o4_SlipCnt, 0);
        chk({tag, "_data"}, {o_RxDataValid, o_RxCodeCtrl, o8_RxCodeGroup}, 0);
    endtask

    initial begin
        int nslips;
        int last_slip;
        bit seen;
        logic p, c, v;
        logic [7:0] g;

        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle_io(1'b1, 8'h50, 1'b0, 1'b0);

        // aligned K28.5 / D16.2 stream
        send_comma();
        step(1'b1, 8'h50, 1'b0, 1'b0);
        chk("verify_after_comma1", o2_State, 2);
        chk("data_lag", {o_RxCodeCtrl, o8_RxCodeGroup}, {1'b1, 8'hBC});
        send_comma();
        step(1'b1, 8'h50, 1'b0, 1'b0);
        send_comma();
        step(1'b1, 8'h50, 1'b0, 1'b0);
        chk("sync_after_comma3", o_SyncStatus, 1);
        chk("no_slip_aligned", o4_SlipCnt, 0);

        // four spaced errors drop sync
        for (int k = 0; k < EM; k++) begin
            send_inv();
            send_d();
        end
        chk("sync_drop_4err", o_SyncStatus, 0);

        // resync, then errors each recovered by a good run
        for (int k = 0; k < CC; k++) begin
            send_comma();
            send_d();
        end
        chk("resync", o_SyncStatus, 1);
        for (int k = 0; k < 3; k++) begin
            send_inv();
            repeat (GR) send_d();
        end
        chk("sync_kept_recovered", o_SyncStatus, 1);
        for (int k = 0; k < EM - 1; k++) begin
            send_inv();
            send_d();
        end
        chk("err_back_to_zero", o_SyncStatus, 1);
        send_inv();
        send_d();
        chk("sync_drop_again", o_SyncStatus, 0);

        // comma spacing 33 in VERIFY returns to HUNT, spacing 32 is tolerated
        send_comma();
        repeat (HW) send_d();
        send_d();
        chk("spacing33_hunt", o2_State, 0);
        chk("spacing33_no_slip", o4_SlipCnt, 0);
        send_comma();
        repeat (HW - 1) send_d();
        send_comma();
        send_d();
        chk("spacing32_verify", o2_State, 2);
        send_inv();
        send_d();
        chk("verify_invalid_hunt", o2_State, 0);

        // comma exactly on the window-expiry cycle
        step(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (HW - 1) send_d();
        send_comma();
        send_d();
        chk("expiry_comma_verify", o2_State, 2);
        chk("expiry_comma_no_slip", o4_SlipCnt, 0);

        // PLL lock loss in SYNC, then held low with no slips
        for (int k = 0; k < CC; k++) begin
            send_comma();
            send_d();
        end
        chk("sync_before_pll", o_SyncStatus, 1);
        step(1'b0, 8'h50, 1'b0, 1'b0);
        send_d();
        chk("pll_drop_sync", o_SyncStatus, 0);
        chk("pll_drop_state", o2_State, 0);
        repeat (50) step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("pll_low_no_slip", o4_SlipCnt, 0);

        // misaligned stream: periodic slips and wrap of the slip counter
        nslips = 0;
        last_slip = -1;
        for (int cyc = 0; cyc < 700 && nslips < 13; cyc++) begin
            send_d();
            if (o_RxBitSlip === 1'b1) begin
                if (last_slip >= 0) chk("slip_spacing", cyc - last_slip, HW + SW);
                last_slip = cyc;
                nslips++;
                if (nslips == 10) chk("slipcnt_wrap", o4_SlipCnt, 0);
            end
        end
        chk("slip_total", nslips, 13);
        for (int k = 0; k < 12; k++) begin
            send_comma();
            send_d();
        end
        chk("sync_after_slips", o_SyncStatus, 1);
        chk("slipcnt_after_slips", o4_SlipCnt, 3);

        // asynchronous reset during SLIP_WAIT
        step(1'b0, 8'h00, 1'b0, 1'b0);
        seen = 0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            send_d();
            seen = (o_RxBitSlip === 1'b1);
        end
        chk("slip_seen_before_arst", seen, 1);
        chk("slip_wait_state", o2_State, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("arst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle_io(1'b1, 8'h50, 1'b0, 1'b0);

        // randomized traffic
        repeat (800) begin
            p = ($urandom_range(0, 99) >= 2);
            g = 8'($urandom_range(0, 255));
            c = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) < 35) begin
                g = 8'hBC;
                c = 1'b1;
            end
            step(p, g, c, v);
        end
        step(1'b1, 8'h50, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
